time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl_pkg.sv | 48 ++++
 rtl/time_set_ctrl_btn_repeat.sv | 62 ++++++
 rtl/time_set_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the 12-hour clock time-set controller: FSM states,
// display field codes, range limits and the wrap-around step helpers.
package time_set_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SET_HR   = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_SET_AMPM = 3'd3,
        ST_APPLY    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        FIELD_NONE    = 2'd0,
        FIELD_HOURS   = 2'd1,
        FIELD_MINUTES = 2'd2,
        FIELD_AMPM    = 2'd3
    } field_t;

    localparam logic [3:0] HOURS_MAX   = 4'd12;
    localparam logic [5:0] MINUTES_MAX = 6'd59;

    // Live time may arrive out of range; clamp it into a legal 12-hour value.
    function automatic logic [3:0] norm_hours(input logic [3:0] h);
        return (h == 4'd0 || h > HOURS_MAX) ? HOURS_MAX : h;
    endfunction

    function automatic logic [5:0] norm_minutes(input logic [5:0] m);
        return (m > MINUTES_MAX) ? 6'd0 : m;
    endfunction

    function automatic logic [3:0] hour_up(input logic [3:0] h);
        return (h >= HOURS_MAX) ? 4'd1 : h + 4'd1;
    endfunction

    function automatic logic [3:0] hour_down(input logic [3:0] h);
        return (h <= 4'd1 || h > HOURS_MAX) ? HOURS_MAX : h - 4'd1;
    endfunction

    function automatic logic [5:0] minute_up(input logic [5:0] m);
        return (m >= MINUTES_MAX) ? 6'd0 : m + 6'd1;
    endfunction

    function automatic logic [5:0] minute_down(input logic [5:0] m);
        return (m == 6'd0 || m > MINUTES_MAX) ? MINUTES_MAX : m - 6'd1;
    endfunction

endpackage

// File: rtl/time_set_ctrl_btn_repeat.sv
// Press detector with hold-then-repeat stepping for one debounced button.
// step fires on the press edge, after HOLD_CYCLES of holding, then every REPEAT_CYCLES.
module btn_repeat #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic block,
    input  logic clear,
    output logic press,
    output logic step
);

    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HOLD_V   = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] REPEAT_V = CW'(REPEAT_CYCLES);
    localparam logic [CW-1:0] SAT_V    = CW'(CNT_MAX);

    logic          prev;
    logic          armed;
    logic          repeating;
    logic [CW-1:0] cnt;
    logic [CW-1:0] thr;

    // armed stays low while a button held across reset remains down, so that
    // hold never counts as a fresh press or drives auto-repeat.
    assign press = btn & ~prev & armed;
    assign thr   = repeating ? REPEAT_V : HOLD_V;
    assign step  = btn & ~block & (press | (armed & (cnt == thr)));

    always_ff @(posedge clk) begin
        if (reset) begin
            prev      <= 1'b0;
            armed     <= ~btn;
            cnt       <= '0;
            repeating <= 1'b0;
        end else begin
            prev <= btn;
            if (!btn) begin
                armed <= 1'b1;
            end

            if (!btn || block || clear) begin
                cnt       <= '0;
                repeating <= 1'b0;
            end else if (press) begin
                cnt       <= CW'(1);
                repeating <= 1'b0;
            end else if (armed && cnt == thr) begin
                cnt       <= CW'(1);
                repeating <= 1'b1;
            end else if (cnt != SAT_V) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time-set FSM for a 12-hour clock: mode walks hours, minutes,
// AM/PM, then a one-cycle propagate loads the edited time downstream.
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES    = 50_000_000,
    parameter int REPEAT_CYCLES  = 10_000_000,
    parameter int TIMEOUT_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       cur_PM,
    input  logic [3:0] cur_hours,
    input  logic [5:0] cur_minutes,
    output logic       propagate,
    output logic       out_PM,
    output logic [3:0] out_hours,
    output logic [5:0] out_minutes,
    output logic       editing,
    output logic [1:0] field,
    output state_t     state_dbg
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_SAT  = TW'(TIMEOUT_CYCLES);

    state_t        state;
    state_t        state_next;
    logic          edit_pm;
    logic          pm_next;
    logic [3:0]    edit_hours;
    logic [3:0]    hours_next;
    logic [5:0]    edit_minutes;
    logic [5:0]    minutes_next;
    logic [TW-1:0] to_cnt;

    logic mode_prev;
    logic mode_armed;
    logic mode_press;
    logic up_press;
    logic up_step;
    logic down_press;
    logic down_step;
    logic any_btn;
    logic both_dir;
    logic timeout_hit;
    logic rpt_clear;

    assign mode_press  = btn_mode & ~mode_prev & mode_armed;
    assign any_btn     = btn_mode | btn_up | btn_down;
    assign both_dir    = btn_up & btn_down;
    assign timeout_hit = ~any_btn & (to_cnt == TO_LAST);
    // Repeat timing restarts whenever the FSM moves and is idle outside edit states.
    assign rpt_clear   = (state_next != state) | ~editing;

    btn_repeat #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_up (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_up),
        .block(both_dir),
        .clear(rpt_clear),
        .press(up_press),
        .step (up_step)
    );

    btn_repeat #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_down (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_down),
        .block(both_dir),
        .clear(rpt_clear),
        .press(down_press),
        .step (down_step)
    );

    always_comb begin
        state_next   = state;
        pm_next      = edit_pm;
        hours_next   = edit_hours;
        minutes_next = edit_minutes;
        propagate    = 1'b0;
        editing      = 1'b0;
        field        = FIELD_NONE;

        case (state)
            ST_IDLE: begin
                if (mode_press) begin
                    state_next   = ST_SET_HR;
                    pm_next      = cur_PM;
                    hours_next   = norm_hours(cur_hours);
                    minutes_next = norm_minutes(cur_minutes);
                end
            end
            ST_SET_HR: begin
                editing = 1'b1;
                field   = FIELD_HOURS;
                if (mode_press) begin
                    state_next = ST_SET_MIN;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end else if (up_step) begin
                    hours_next = hour_up(edit_hours);
                end else if (down_step) begin
                    hours_next = hour_down(edit_hours);
                end
            end
            ST_SET_MIN: begin
                editing = 1'b1;
                field   = FIELD_MINUTES;
                if (mode_press) begin
                    state_next = ST_SET_AMPM;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end else if (up_step) begin
                    minutes_next = minute_up(edit_minutes);
                end else if (down_step) begin
                    minutes_next = minute_down(edit_minutes);
                end
            end
            ST_SET_AMPM: begin
                editing = 1'b1;
                field   = FIELD_AMPM;
                if (mode_press) begin
                    state_next = ST_APPLY;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end else if (up_step || down_step) begin
                    pm_next = ~edit_pm;
                end
            end
            ST_APPLY: begin
                propagate  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            edit_pm      <= 1'b0;
            edit_hours   <= HOURS_MAX;
            edit_minutes <= 6'd0;
            to_cnt       <= '0;
            mode_prev    <= 1'b0;
            mode_armed   <= ~btn_mode;
        end else begin
            state        <= state_next;
            edit_pm      <= pm_next;
            edit_hours   <= hours_next;
            edit_minutes <= minutes_next;
            mode_prev    <= btn_mode;
            if (!btn_mode) begin
                mode_armed <= 1'b1;
            end

            if (state_next != state || !editing || any_btn) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_SAT) begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

    assign out_PM      = edit_pm;
    assign out_hours   = edit_hours;
    assign out_minutes = edit_minutes;
    assign state_dbg   = state;

    // Press strobes are consumed through step; the raw edges are not needed here.
    logic unused_press;
    assign unused_press = up_press ^ down_press;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed scenarios plus randomized
// button traffic against a cycle-level model of the time-set rules.
module tb_time_set_ctrl;
    import time_set_ctrl_pkg::*;

    localparam int HOLD = 4;
    localparam int REP  = 2;
    localparam int TMO  = 5;
    localparam int NONE = -1000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       cur_PM = 1'b0;
    logic [3:0] cur_hours = 4'd0;
    logic [5:0] cur_minutes = 6'd0;
    logic       propagate;
    logic       out_PM;
    logic [3:0] out_hours;
    logic [5:0] out_minutes;
    logic       editing;
    logic [1:0] field;
    state_t     state_dbg;

    logic [14:0] dut_vec;
    assign dut_vec = {propagate, editing, field, out_PM, out_hours, out_minutes};

    localparam logic [14:0] RESET_VEC = {1'b0, 1'b0, 2'd0, 1'b0, 4'd12, 6'd0};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    time_set_ctrl #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .cur_PM     (cur_PM),
        .cur_hours  (cur_hours),
        .cur_minutes(cur_minutes),
        .propagate  (propagate),
        .out_PM     (out_PM),
        .out_hours  (out_hours),
        .out_minutes(out_minutes),
        .editing    (editing),
        .field      (field),
        .state_dbg  (state_dbg)
    );

    // Reference model: st 0=idle 1=hours 2=minutes 3=ampm 4=apply.
    // t_held counts held cycles since the last press (NONE = no press owns the hold).
    int m_st, m_h, m_m, m_pm, m_idle;
    int m_t[2];
    bit m_prev[3];
    bit m_blk[3];

    task automatic model_edge();
        bit b[3];
        bit pr[3];
        bit stp[2];
        bit both, any_b, edit;
        int ns, d;
        b[0] = btn_mode; b[1] = btn_up; b[2] = btn_down;
        if (reset) begin
            m_st = 0; m_h = 12; m_m = 0; m_pm = 0; m_idle = 0;
            for (int i = 0; i < 3; i++) begin
                m_prev[i] = 1'b0;
                m_blk[i]  = b[i];
            end
            m_t[0] = NONE; m_t[1] = NONE;
        end else begin
            for (int i = 0; i < 3; i++) pr[i] = b[i] && !m_prev[i] && !m_blk[i];
            both  = b[1] && b[2];
            any_b = b[0] || b[1] || b[2];
            for (int i = 0; i < 2; i++) begin
                stp[i] = 1'b0;
                if (!b[i+1]) m_t[i] = NONE;
                else if (both) m_t[i] = (pr[i+1] || m_t[i] != NONE) ? -1 : NONE;
                else if (pr[i+1]) begin
                    m_t[i] = 0;
                    stp[i] = 1'b1;
                end else if (m_t[i] != NONE) begin
                    m_t[i]++;
                    stp[i] = (m_t[i] == HOLD) || (m_t[i] > HOLD && (m_t[i] - HOLD) % REP == 0);
                end
            end
            edit = (m_st >= 1 && m_st <= 3);
            ns = m_st;
            if (m_st == 0) begin
                if (pr[0]) begin
                    ns   = 1;
                    m_pm = int'(cur_PM);
                    m_h  = (cur_hours == 0 || cur_hours > 12) ? 12 : int'(cur_hours);
                    m_m  = (cur_minutes > 59) ? 0 : int'(cur_minutes);
                end
            end else if (m_st == 4) ns = 0;
            else if (pr[0]) ns = m_st + 1;
            else if (!any_b && m_idle + 1 >= TMO) ns = 0;
            else if (stp[0] || stp[1]) begin
                d = stp[0] ? 1 : -1;
                case (m_st)
                    1: m_h = (m_h - 1 + d + 12) % 12 + 1;
                    2: m_m = (m_m + d + 60) % 60;
                    default: m_pm = 1 - m_pm;
                endcase
            end
            if (ns != m_st || !edit || any_b) m_idle = 0;
            else m_idle++;
            if (ns != m_st || !edit) begin
                for (int i = 0; i < 2; i++) if (m_t[i] != NONE) m_t[i] = -1;
            end
            m_st = ns;
            for (int i = 0; i < 3; i++) begin
                m_prev[i] = b[i];
                if (!b[i]) m_blk[i] = 1'b0;
            end
        end
    endtask

    function automatic logic [14:0] exp_vec();
        logic [1:0] f;
        f = (m_st >= 1 && m_st <= 3) ? 2'(m_st) : 2'd0;
        return {(m_st == 4), (m_st >= 1 && m_st <= 3), f, m_pm[0], 4'(m_h), 6'(m_m)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic drive(input bit m, input bit u, input bit d);
        btn_mode = m; btn_up = u; btn_down = d;
        tick();
    endtask

    task automatic idle_out();
        repeat (TMO + 1) drive(0, 0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 0);
        drive(0, 0, 0);
        checks++;
        if (dut_vec !== RESET_VEC || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state got %h/%0d expected %h/%0d", dut_vec, state_dbg, RESET_VEC, ST_IDLE);
        end
        reset = 1'b0;
        drive(0, 0, 0);
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_release got %h expected %h", dut_vec, RESET_VEC);
        end
    endtask

    task automatic test_basic_apply();
        int pulses = 0;
        cur_PM = 1'b1; cur_hours = 4'd3; cur_minutes = 6'd7;
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0);
            if (propagate) pulses++;
            checks++;
            if (k < 3 && (editing !== 1'b1 || field !== 2'(k + 1) || {out_PM, out_hours, out_minutes} !== {1'b1, 4'd3, 6'd7})) begin
                errors++;
                $display("FAIL basic_edit k=%0d got ed=%b fld=%0d %0d:%0d pm=%b expected ed=1 fld=%0d 3:7 pm=1", k, editing, field, out_hours, out_minutes, out_PM, k + 1);
            end else if (k == 3 && (propagate !== 1'b1 || editing !== 1'b0 || {out_PM, out_hours, out_minutes} !== {1'b1, 4'd3, 6'd7})) begin
                errors++;
                $display("FAIL basic_apply got prop=%b ed=%b %0d:%0d pm=%b expected prop=1 ed=0 3:7 pm=1", propagate, editing, out_hours, out_minutes, out_PM);
            end
            drive(0, 0, 0);
            if (propagate) pulses++;
        end
        checks++;
        if (pulses != 1 || state_dbg !== ST_IDLE || propagate !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse got pulses=%0d state=%0d expected pulses=1 state=0", pulses, state_dbg);
        end
    endtask

    task automatic test_wrap();
        cur_PM = 1'b0; cur_hours = 4'd12; cur_minutes = 6'd59;
        drive(1, 0, 0); drive(0, 0, 0);
        drive(0, 1, 0);
        checks++;
        if (out_hours !== 4'd1 || out_PM !== 1'b0) begin
            errors++;
            $display("FAIL wrap_hours got %0d pm=%b expected 1 pm=0", out_hours, out_PM);
        end
        drive(0, 0, 0);
        drive(1, 0, 0); drive(0, 0, 0);
        drive(0, 1, 0);
        checks++;
        if (out_minutes !== 6'd0 || out_hours !== 4'd1 || out_PM !== 1'b0) begin
            errors++;
            $display("FAIL wrap_minutes got %0d:%0d pm=%b expected 1:0 pm=0", out_hours, out_minutes, out_PM);
        end
        drive(0, 0, 0);
        drive(1, 0, 0); drive(0, 0, 0);
        drive(0, 1, 0);
        checks++;
        if (out_PM !== 1'b1 || field !== 2'd3) begin
            errors++;
            $display("FAIL wrap_ampm got pm=%b fld=%0d expected pm=1 fld=3", out_PM, field);
        end
        drive(0, 0, 0);
        drive(1, 0, 0);
        checks++;
        if (propagate !== 1'b1 || {out_PM, out_hours, out_minutes} !== {1'b1, 4'd1, 6'd0}) begin
            errors++;
            $display("FAIL wrap_apply got prop=%b %0d:%0d pm=%b expected prop=1 1:0 pm=1", propagate, out_hours, out_minutes, out_PM);
        end
        drive(0, 0, 0);
    endtask

    task automatic test_normalize();
        cur_PM = 1'b0; cur_hours = 4'd0; cur_minutes = 6'd63;
        drive(1, 0, 0);
        checks++;
        if (out_hours !== 4'd12 || out_minutes !== 6'd0) begin
            errors++;
            $display("FAIL norm_load got %0d:%0d expected 12:0", out_hours, out_minutes);
        end
        drive(0, 0, 0);
        drive(0, 0, 1);
        checks++;
        if (out_hours !== 4'd11) begin
            errors++;
            $display("FAIL norm_down got %0d expected 11", out_hours);
        end
        idle_out();
        cur_hours = 4'd13; cur_minutes = 6'd30;
        drive(1, 0, 0);
        checks++;
        if (out_hours !== 4'd12 || out_minutes !== 6'd30) begin
            errors++;
            $display("FAIL norm_high got %0d:%0d expected 12:30", out_hours, out_minutes);
        end
        idle_out();
    endtask

    task automatic test_hold_repeat();
        int tab[9];
        tab = '{11, 11, 11, 11, 12, 12, 13, 13, 14};
        cur_PM = 1'b0; cur_hours = 4'd5; cur_minutes = 6'd10;
        drive(1, 0, 0); drive(0, 0, 0);
        drive(1, 0, 0); drive(0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            drive(0, 1, 0);
            checks++;
            if (out_minutes !== 6'(tab[i])) begin
                errors++;
                $display("FAIL hold_repeat edge=%0d got %0d expected %0d", i, out_minutes, tab[i]);
            end
        end
        drive(0, 0, 0);
        checks++;
        if (out_minutes !== 6'd14 || editing !== 1'b1) begin
            errors++;
            $display("FAIL hold_release got %0d ed=%b expected 14 ed=1", out_minutes, editing);
        end
        idle_out();
    endtask

    task automatic test_timeout();
        int pulses = 0;
        drive(1, 0, 0); drive(0, 0, 0);
        drive(1, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0);
            if (propagate) pulses++;
            checks++;
            if (editing !== 1'b1 || field !== 2'd2) begin
                errors++;
                $display("FAIL timeout_early cycle=%0d got ed=%b fld=%0d expected ed=1 fld=2", i, editing, field);
            end
        end
        drive(0, 0, 0);
        if (propagate) pulses++;
        checks++;
        if (editing !== 1'b0 || field !== 2'd0 || state_dbg !== ST_IDLE || pulses != 0) begin
            errors++;
            $display("FAIL timeout_abort got ed=%b fld=%0d state=%0d pulses=%0d expected ed=0 fld=0 state=0 pulses=0", editing, field, state_dbg, pulses);
        end
        drive(1, 0, 0); drive(0, 0, 0);
        drive(0, 1, 0);
        reset = 1'b1;
        drive(0, 0, 0);
        checks++;
        if (dut_vec !== RESET_VEC || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_mid_edit got %h expected %h", dut_vec, RESET_VEC);
        end
        reset = 1'b0;
        drive(0, 0, 0);
        checks++;
        if (propagate !== 1'b0 || editing !== 1'b0) begin
            errors++;
            $display("FAIL reset_after got prop=%b ed=%b expected 0 0", propagate, editing);
        end
    endtask

    task automatic test_conflict();
        cur_PM = 1'b1; cur_hours = 4'd8; cur_minutes = 6'd20;
        drive(1, 0, 0); drive(0, 0, 0);
        drive(1, 0, 0); drive(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1);
            checks++;
            if (out_minutes !== 6'd20) begin
                errors++;
                $display("FAIL both_dir cycle=%0d got %0d expected 20", i, out_minutes);
            end
        end
        idle_out();
        drive(1, 0, 0); drive(0, 0, 0);
        drive(1, 1, 0);
        checks++;
        if (field !== 2'd2 || out_hours !== 4'd8) begin
            errors++;
            $display("FAIL mode_up got fld=%0d hr=%0d expected fld=2 hr=8", field, out_hours);
        end
        idle_out();
    endtask

    task automatic test_reset_held();
        reset = 1'b1;
        drive(1, 0, 0); drive(1, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0);
            checks++;
            if (editing !== 1'b0) begin
                errors++;
                $display("FAIL held_reset cycle=%0d got ed=%b expected 0", i, editing);
            end
        end
        drive(0, 0, 0);
        drive(1, 0, 0);
        checks++;
        if (editing !== 1'b1 || field !== 2'd1) begin
            errors++;
            $display("FAIL held_repress got ed=%b fld=%0d expected ed=1 fld=1", editing, field);
        end
        idle_out();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 3) == 0) btn_mode = ~btn_mode;
            if ($urandom_range(0, 5) == 0) btn_up = ~btn_up;
            if ($urandom_range(0, 5) == 0) btn_down = ~btn_down;
            if ($urandom_range(0, 15) == 0) begin
                cur_PM      = 1'($urandom_range(0, 1));
                cur_hours   = 4'($urandom_range(0, 15));
                cur_minutes = 6'($urandom_range(0, 63));
            end
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random cycle=%0d got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        reset = 1'b0;
        idle_out();
    endtask

    initial begin
        test_reset();
        test_basic_apply();
        test_wrap();
        test_normalize();
        test_hold_repeat();
        test_timeout();
        test_conflict();
        test_reset_held();
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL directed_model got %h expected %h", dut_vec, exp_vec());
        end
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
